multicycle_datapath: RTL
========================

MULTICYCLE_DATAPATH -- requirements
Module: multicycle_datapath

Interface
REQ-001 Parameter DATA_W, default 24, register/ALU/memory data width, legal range 24..32; instruction occupies mem_rdata[23:0].
REQ-002 Parameter ADDR_W, default 24, PC and memory address width.
REQ-003 Parameter RESET_PC, default 10, PC value loaded by reset.
REQ-004 Parameter PC_STEP, default 3, address increment per instruction.
REQ-005 Clock  input  1  single clock; all state updates on rising edge.
REQ-006 Reset_n  input  1  asynchronous, active-low reset.
REQ-007 mem_req  output  1  memory access request, held until accepted.
REQ-008 mem_we  output  1  1 = write, 0 = read; valid while mem_req=1.
REQ-009 mem_addr  output  ADDR_W  access address; stable while mem_req=1.
REQ-010 mem_wdata  output  DATA_W  store data; stable while mem_req=1.
REQ-011 mem_rdata  input  DATA_W  read data, sampled on the accepting edge.
REQ-012 mem_ready  input  1  accept; transfer completes on an edge with mem_req=1 and mem_ready=1.
REQ-013 pc  output  ADDR_W  address of the current instruction.
REQ-014 state  output  3  FSM state code: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5.
REQ-015 retire  output  1  one-cycle pulse when an instruction completes.
REQ-016 halted  output  1  high in HALT.
REQ-017 illegal  output  1  sticky; set when an undefined opcode is decoded.

Function
REQ-018 Format: op[23:20], rs[19:16], rt[15:12], rd[11:8], funct[3:0], imm[11:0] sign-extended to DATA_W, target[19:0] zero-extended to ADDR_W.
REQ-019 Register file: 16 x DATA_W; r0 reads 0 and ignores writes; two reads, one write per cycle.
REQ-020 Opcodes: 0 R-type, 1 ADDI, 2 LW, 3 SW, 4 BEQ, 5 BNE, 6 J, 7 SLTI, F HALT; all others illegal.
REQ-021 R-type funct: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT (signed), 6 SLL, 7 SRL (shift amount = rt value[4:0]); other funct are illegal.
REQ-022 Arithmetic wraps modulo 2^DATA_W; no overflow trap; SLT/SLTI write 1 or 0.
REQ-023 FETCH: mem_req=1, mem_we=0, mem_addr=pc; on acceptance latch IR, go to DECODE; otherwise stay in FETCH.
REQ-024 DECODE: read rs/rt into A/B; illegal op/funct -> set illegal, go to HALT; HALT op -> go to HALT; else go to EXEC.
REQ-025 EXEC: compute ALU result; LW/SW address = A + imm (truncated to ADDR_W).
REQ-026 EXEC, BEQ/BNE: taken -> pc <= pc + PC_STEP + imm*PC_STEP; not taken -> pc <= pc + PC_STEP; retire; go to FETCH.
REQ-027 EXEC, J: pc <= target; retire; go to FETCH.
REQ-028 EXEC, LW/SW -> MEM; R-type/ADDI/SLTI -> WB.
REQ-029 MEM: mem_req=1, mem_we=1 for SW (mem_wdata=B), 0 for LW; hold until accepted; SW on accept: pc += PC_STEP, retire, FETCH; LW on accept: latch data, go to WB.
REQ-030 WB: write rd (R-type) or rt (ADDI, SLTI, LW); pc += PC_STEP; retire; go to FETCH.
REQ-031 Latency at zero wait states: R/ADDI/SLTI 4, LW 5, SW 4, BEQ/BNE/J 3, HALT 2 cycles; each mem_ready-low cycle adds one.
REQ-032 PC arithmetic wraps modulo 2^ADDR_W.
REQ-033 HALT is terminal until reset; mem_req=0, retire=0.
REQ-034 mem_req=0 in DECODE, EXEC, WB and HALT; mem_ready is ignored when mem_req=0.

Reset
REQ-035 While Reset_n=0: pc=RESET_PC, state=FETCH, IR=0, all registers=0, mem_req driven with FETCH values after release, retire=0, halted=0, illegal=0.
REQ-036 Reset asserted mid-access aborts the transfer immediately; no register write and no retire for the in-flight instruction.

Verification
REQ-037 Reset release, mem_ready=1, mem[10]=ADDI r1,r0,5 -> mem_addr=10 first cycle; retire in cycle 4; r1=5; pc=13.
REQ-038 r1=5, r2=5, BEQ r1,r2,imm=-1 at pc=13 -> pc=13 after 3 cycles; BNE with same operands -> pc=16.
REQ-039 SW r1 to 0x40 then LW r3 from 0x40, mem_ready low 2 cycles per access -> SW 6 cycles, LW 7 cycles, r3=5, mem_we=1 only on the SW MEM access.
REQ-040 ADD r0,r1,r1 then SUB r4,r0,r1 (r1=5) -> r0 stays 0; r4=0xFFFFFB for DATA_W=24.
REQ-041 Opcode 0xA fetched -> illegal=1 and halted=1 after DECODE; mem_req stays 0 until Reset_n pulse.
REQ-042 Reset_n pulled low during a stalled LW MEM -> state=FETCH, pc=10 asynchronously; destination register is unchanged.

Source files
------------

// File: rtl/multicycle_datapath.sv
// Multicycle 24-bit-instruction processor datapath: FETCH/DECODE/EXEC/MEM/WB
// controller with a 16-entry register file and a single shared memory port.
module multicycle_datapath #(
  parameter int DATA_W   = 24,
  parameter int ADDR_W   = 24,
  parameter int RESET_PC = 10,
  parameter int PC_STEP  = 3
) (
  input  logic              Clock,
  input  logic              Reset_n,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] pc,
  output logic [2:0]        state,
  output logic              retire,
  output logic              halted,
  output logic              illegal
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam logic [3:0] OP_R    = 4'h0;
  localparam logic [3:0] OP_ADDI = 4'h1;
  localparam logic [3:0] OP_LW   = 4'h2;
  localparam logic [3:0] OP_SW   = 4'h3;
  localparam logic [3:0] OP_BEQ  = 4'h4;
  localparam logic [3:0] OP_BNE  = 4'h5;
  localparam logic [3:0] OP_J    = 4'h6;
  localparam logic [3:0] OP_SLTI = 4'h7;
  localparam logic [3:0] OP_HALT = 4'hF;

  state_t              r_state;
  state_t              w_next;
  logic [ADDR_W-1:0]   r_pc;
  logic [23:0]         r_ir;
  logic [DATA_W-1:0]   r_a;
  logic [DATA_W-1:0]   r_b;
  logic [DATA_W-1:0]   r_alu;
  logic [DATA_W-1:0]   r_mdr;
  logic                r_illegal;
  logic [DATA_W-1:0]   r_regs [16];

  logic [3:0]          w_op;
  logic [3:0]          w_rs;
  logic [3:0]          w_rt;
  logic [3:0]          w_rd;
  logic [3:0]          w_funct;
  logic [DATA_W-1:0]   w_imm;
  logic [ADDR_W-1:0]   w_imm_a;
  logic [ADDR_W-1:0]   w_target;
  logic [ADDR_W-1:0]   w_pc_seq;
  logic [ADDR_W-1:0]   w_pc_br;
  logic [ADDR_W-1:0]   w_daddr;
  logic                w_taken;
  logic                w_bad_dec;
  logic                w_is_ctl;
  logic [DATA_W-1:0]   w_alu;
  logic [3:0]          w_dest;
  logic [DATA_W-1:0]   w_wb_data;

  assign w_op     = r_ir[23:20];
  assign w_rs     = r_ir[19:16];
  assign w_rt     = r_ir[15:12];
  assign w_rd     = r_ir[11:8];
  assign w_funct  = r_ir[3:0];
  assign w_imm    = {{(DATA_W-12){r_ir[11]}}, r_ir[11:0]};
  assign w_imm_a  = {{(ADDR_W-12){r_ir[11]}}, r_ir[11:0]};
  assign w_target = {{(ADDR_W-20){1'b0}}, r_ir[19:0]};
  assign w_pc_seq = r_pc + ADDR_W'(PC_STEP);
  // Branch offset is counted in instructions, so it is scaled by the PC step.
  assign w_pc_br  = w_pc_seq + w_imm_a * ADDR_W'(PC_STEP);
  assign w_taken  = (w_op == OP_BEQ) ? (r_a == r_b) : (r_a != r_b);
  assign w_is_ctl = (w_op == OP_BEQ) || (w_op == OP_BNE) || (w_op == OP_J);
  assign w_daddr  = ADDR_W'(r_alu);
  assign w_dest   = (w_op == OP_R) ? w_rd : w_rt;
  assign w_wb_data = (w_op == OP_LW) ? r_mdr : r_alu;

  always_comb begin
    w_bad_dec = 1'b0;
    case (w_op)
      OP_R:                                   w_bad_dec = (w_funct > 4'd7);
      OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_BNE,
      OP_J, OP_SLTI, OP_HALT:                 w_bad_dec = 1'b0;
      default:                                w_bad_dec = 1'b1;
    endcase
  end

  always_comb begin
    w_alu = r_a + w_imm;
    if (w_op == OP_R) begin
      case (w_funct)
        4'd0:    w_alu = r_a + r_b;
        4'd1:    w_alu = r_a - r_b;
        4'd2:    w_alu = r_a & r_b;
        4'd3:    w_alu = r_a | r_b;
        4'd4:    w_alu = r_a ^ r_b;
        4'd5:    w_alu = {{(DATA_W-1){1'b0}}, ($signed(r_a) < $signed(r_b))};
        4'd6:    w_alu = r_a << r_b[4:0];
        4'd7:    w_alu = r_a >> r_b[4:0];
        default: w_alu = '0;
      endcase
    end else if (w_op == OP_SLTI) begin
      w_alu = {{(DATA_W-1){1'b0}}, ($signed(r_a) < $signed(w_imm))};
    end
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) r_state <= S_FETCH;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH:  if (mem_ready) w_next = S_DECODE;
      S_DECODE: w_next = (w_bad_dec || w_op == OP_HALT) ? S_HALT : S_EXEC;
      S_EXEC: begin
        if (w_is_ctl)                             w_next = S_FETCH;
        else if (w_op == OP_LW || w_op == OP_SW)  w_next = S_MEM;
        else                                      w_next = S_WB;
      end
      S_MEM:    if (mem_ready) w_next = (w_op == OP_SW) ? S_FETCH : S_WB;
      S_WB:     w_next = S_FETCH;
      S_HALT:   w_next = S_HALT;
      default:  w_next = S_FETCH;
    endcase
  end

  always_comb begin
    mem_req   = (r_state == S_FETCH) || (r_state == S_MEM);
    mem_we    = (r_state == S_MEM) && (w_op == OP_SW);
    mem_addr  = (r_state == S_MEM) ? w_daddr : r_pc;
    mem_wdata = r_b;
    retire    = ((r_state == S_EXEC) && w_is_ctl) ||
                ((r_state == S_MEM) && (w_op == OP_SW) && mem_ready) ||
                (r_state == S_WB);
    halted    = (r_state == S_HALT);
    illegal   = r_illegal;
    pc        = r_pc;
    state     = r_state;
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      r_pc      <= ADDR_W'(RESET_PC);
      r_ir      <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_alu     <= '0;
      r_mdr     <= '0;
      r_illegal <= 1'b0;
      for (int unsigned i = 0; i < 16; i++) r_regs[i] <= '0;
    end else begin
      case (r_state)
        S_FETCH: if (mem_ready) r_ir <= mem_rdata[23:0];
        S_DECODE: begin
          r_a <= r_regs[w_rs];
          r_b <= r_regs[w_rt];
          if (w_bad_dec) r_illegal <= 1'b1;
        end
        S_EXEC: begin
          r_alu <= w_alu;
          if (w_op == OP_J)   r_pc <= w_target;
          else if (w_is_ctl)  r_pc <= w_taken ? w_pc_br : w_pc_seq;
        end
        S_MEM: if (mem_ready) begin
          if (w_op == OP_SW) r_pc  <= w_pc_seq;
          else               r_mdr <= mem_rdata;
        end
        S_WB: begin
          // r0 is never written, so it reads back as zero without a read mux.
          if (w_dest != 4'd0) r_regs[w_dest] <= w_wb_data;
          r_pc <= w_pc_seq;
        end
        default: ;
      endcase
    end
  end

endmodule
